inc_step_counter: RTL

Registered, parametrised successor to the combinational incrementer in the datapath component library. Holds a DATAWIDTH-bit value and advances it each enabled cycle by a runtime step, up or down, within a runtime bound [0, limit]. The bound is handled by wrap or saturate mode. Provides a terminal-count pulse and a sticky overflow flag. Used by HLS-generated datapaths as loop-index and address generators.

---
 rtl/inc_step_counter_pkg.sv | 19 +
 rtl/inc_step_next.sv | 57 +++++
 rtl/inc_step_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/inc_step_counter_pkg.sv
// Shared definitions for the step counter: bound-handling modes,
// the default datapath width and the per-edge action encoding.
package inc_step_counter_pkg;

  // Bound-handling modes for the WRAP parameter
  localparam bit MODE_SATURATE = 1'b0;
  localparam bit MODE_WRAP     = 1'b1;

  // Default width of value, step, limit and load data
  localparam int DEFAULT_DATAWIDTH = 64;

  // What the counter register does on a given edge once reset is released
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2
  } countAction_e;

endpackage

// File: rtl/inc_step_next.sv
// Combinational next-value logic for the step counter: clamps the step to
// the limit, guards against a count that sits above a lowered limit, and
// applies the up/down step with wrap or saturate handling at the bounds.
module inc_step_next
  import inc_step_counter_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter bit WRAP      = MODE_WRAP
) (
  input  logic [DATAWIDTH-1:0] q_i,
  input  logic [DATAWIDTH-1:0] step_i,
  input  logic [DATAWIDTH-1:0] limit_i,
  input  logic                 up_i,
  output logic [DATAWIDTH-1:0] next_q_o,
  output logic                 cross_o
);

  localparam logic [DATAWIDTH-1:0] One = DATAWIDTH'(1);

  logic [DATAWIDTH-1:0] stepEff;
  logic [DATAWIDTH-1:0] headroom;

  // Step clamp and the room left below the limit for an up step
  always_comb begin
    stepEff  = (step_i > limit_i) ? limit_i : step_i;
    headroom = limit_i - stepEff;
  end

  // Next value and crossing flag. The wrap results equal the
  // (DATAWIDTH+1)-bit forms sum-(limit+1) and q+(limit+1)-step, but are
  // rearranged so every intermediate fits in DATAWIDTH bits: when
  // q <= limit, "q + step > limit" is exactly "q > limit - step", and the
  // rearranged subtractions can never underflow in the branches using them.
  always_comb begin
    next_q_o = q_i;
    cross_o  = 1'b0;
    if (q_i > limit_i) begin
      cross_o  = 1'b1;
      next_q_o = WRAP ? '0 : limit_i;
    end else if (up_i) begin
      if (q_i > headroom) begin
        cross_o  = 1'b1;
        next_q_o = WRAP ? (q_i - headroom - One) : limit_i;
      end else begin
        next_q_o = q_i + stepEff;
      end
    end else begin
      if (q_i >= stepEff) begin
        next_q_o = q_i - stepEff;
      end else begin
        cross_o  = 1'b1;
        next_q_o = WRAP ? (limit_i - (stepEff - q_i - One)) : '0;
      end
    end
  end

endmodule

// File: rtl/inc_step_counter.sv
// Registered step counter: holds the count, terminal-count pulse and sticky
// overflow flag, and arbitrates reset > load > enable on each clock edge.
module inc_step_counter
  import inc_step_counter_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
  parameter bit WRAP      = MODE_WRAP
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] ld_val,
  input  logic                 up,
  input  logic [DATAWIDTH-1:0] step,
  input  logic [DATAWIDTH-1:0] limit,
  output logic [DATAWIDTH-1:0] q,
  output logic                 tc,
  output logic                 ovf
);

  logic [DATAWIDTH-1:0] count_q, count_d;
  logic                 tc_q, tc_d;
  logic                 ovf_q, ovf_d;
  logic [DATAWIDTH-1:0] stepNext;
  logic                 stepCross;
  countAction_e         action;

  inc_step_next #(
    .DATAWIDTH(DATAWIDTH),
    .WRAP     (WRAP)
  ) u_next (
    .q_i     (count_q),
    .step_i  (step),
    .limit_i (limit),
    .up_i    (up),
    .next_q_o(stepNext),
    .cross_o (stepCross)
  );

  // Load takes priority over stepping when both are requested
  always_comb begin
    action = ACT_HOLD;
    if (load) begin
      action = ACT_LOAD;
    end else if (en) begin
      action = ACT_STEP;
    end
  end

  // Next register values for the selected action; tc only lives one cycle
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    unique case (action)
      ACT_LOAD: begin
        count_d = (ld_val > limit) ? limit : ld_val;
        ovf_d   = 1'b0;
      end
      ACT_STEP: begin
        count_d = stepNext;
        tc_d    = stepCross;
        ovf_d   = ovf_q | stepCross;
      end
      default: begin
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = count_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule
